booth_seq_mult: RTL and testbench
=================================

Name: booth_seq_mult

Overview:
- Iterative signed radix-4 Booth multiplier sequencer: retires one Booth digit per clock from a WIDTH-bit multiplier.
- Each digit is encoded with the team's radix-4 Booth encoding: zero / double / negation from bit triplet {b[2i+1], b[2i], b[2i-1]}, with b[-1]=0.
- Selected partial product is accumulated into a 2*WIDTH-bit register.
- Sits between a requester (valid/ready) and a consumer (valid/ready); one operation in flight, no pipelining.

Parameters:
- WIDTH, 16, operand width in bits; must be even and >= 4.
- CNT_W, $clog2(WIDTH/2)+1, digit counter width; derived, not overridden.

Ports:
- clk  input  1  single clock; all state changes on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operands valid.
- in_ready  output  1  block can accept operands (high only in IDLE).
- a  input  WIDTH  signed multiplicand.
- b  input  WIDTH  signed multiplier.
- busy  output  1  high in RUN.
- out_valid  output  1  product valid; held until accepted.
- out_ready  input  1  consumer accepts product.
- product  output  2*WIDTH  signed a*b, two's complement.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high (ports clk, rst).
- Reset values: state=IDLE, in_ready=0 during the rst cycle and 1 after, busy=0, out_valid=0, product=0, counter=0, accumulator=0.
- rst has priority over everything. Asserting it mid-RUN or in DONE aborts the operation; the partial result is discarded and no out_valid is produced.
- States:
  - IDLE: in_ready=1.
  - RUN: busy=1.
  - DONE: out_valid=1.
- IDLE->RUN on in_valid&in_ready at edge k:
  - Latch a (sign-extended to 2*WIDTH).
  - Latch multiplier shift register {b, 1'b0}.
  - Clear accumulator; counter=0.
- RUN, each edge:
  - Take triplet from the low 3 bits of the shift register.
  - zero = (t==000)|(t==111).
  - double = (t==100)|(t==011).
  - negation = t[2] & ~(t[1]&t[0]).
  - pp = zero ? 0 : (double ? a<<1 : a); pp = negation ? -pp : pp. Code 111 yields 0, not -0 handling.
  - acc += pp << (2*counter), modulo 2^(2*WIDTH).
  - Shift the register right by 2 (arithmetic); counter++.
- RUN->DONE on the edge retiring digit WIDTH/2-1. product <= final acc on that same edge.
- Latency: out_valid high after edge k+WIDTH/2 (8 cycles for WIDTH=16).
- DONE:
  - product and out_valid stay stable until out_valid&out_ready.
  - Then go to IDLE; out_valid=0; product holds its last value.
  - in_ready rises the cycle after acceptance. No same-cycle accept/issue.
- in_valid while not in_ready is ignored; operands are not captured.
- Inputs a and b are sampled only at accept; later changes have no effect.
- Most-negative operands (-2^(WIDTH-1)) are handled exactly. The 2*WIDTH-bit result never overflows.

Optional Feature:
- Macro: BOOTH_SKIP_EN.
- Defined: after retiring digit i, if remaining multiplier bits b[WIDTH-1:2i+1] are all 0 or all 1, every remaining digit is zero.
  - Go to DONE on that edge; product = acc.
  - Latency is 1..WIDTH/2 cycles.
  - A digit is always retired, so b=0 takes 1 cycle.
- Undefined: fixed WIDTH/2-cycle latency; no skip logic synthesized.
- The product value is identical in both builds.

Test Plan:
- WIDTH=16, a=3, b=5, out_ready=1 -> out_valid exactly 8 cycles after accept, product=0x0000000F; in_ready high again the following cycle.
- a=-7 (0xFFF9), b=6 -> product=0xFFFFFFD6 (-42).
- a=b=0x8000 -> product=0x40000000. Also a=0x8000, b=0x7FFF -> 0xC0008000.
- out_ready held 0 for 5 cycles in DONE -> product/out_valid stable, in_ready=0, a new in_valid is not captured; accepted on the 6th cycle.
- rst asserted at RUN digit 3 -> next cycle state IDLE, out_valid=0, product=0. A following a=2, b=2 -> product=4 at normal latency.
- BOOTH_SKIP_EN: b=1 -> 1 cycle; b=-1 (0xFFFF), a=9 -> 1 cycle, product=0xFFFFFFF7. b=0x4000 -> 8 cycles. Without the macro, all of these take 8 cycles with the same products.

Source files
------------

// File: rtl/booth_seq_mult.sv
// Sequential signed radix-4 Booth multiplier: one Booth digit retired per clock, valid/ready on both sides.
// Optional macro BOOTH_SKIP_EN ends the run early once the remaining multiplier digits are all zero.
module booth_seq_mult #(
  parameter int WIDTH = 16,
  localparam int CNT_W = $clog2(WIDTH/2) + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   product
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t               state_q;
  logic [2*WIDTH-1:0]   a_q;
  logic [2*WIDTH-1:0]   acc_q;
  logic [2*WIDTH-1:0]   product_q;
  logic [WIDTH:0]       mreg_q;
  logic [CNT_W-1:0]     cnt_q;

  logic [2:0]           trip;
  logic                 zero, dbl, neg;
  logic [2*WIDTH-1:0]   mag, pp, acc_d;
  logic [WIDTH:0]       mreg_d;
  logic                 last_digit, finish;

  always_comb begin
    trip       = mreg_q[2:0];
    zero       = (trip == 3'b000) | (trip == 3'b111);
    dbl        = (trip == 3'b100) | (trip == 3'b011);
    neg        = trip[2] & ~(trip[1] & trip[0]);
    mag        = zero ? '0 : (dbl ? (a_q << 1) : a_q);
    pp         = neg ? (~mag + 1'b1) : mag;
    acc_d      = acc_q + (pp << {cnt_q, 1'b0});
    mreg_d     = {{2{mreg_q[WIDTH]}}, mreg_q[WIDTH:2]};
    last_digit = (cnt_q == CNT_W'(WIDTH/2 - 1));
`ifdef BOOTH_SKIP_EN
    // The arithmetic shift replicates b's sign, so a uniform register means every remaining digit is zero.
    finish     = last_digit | (&mreg_d) | ~(|mreg_d);
`else
    finish     = last_digit;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      a_q       <= '0;
      acc_q     <= '0;
      product_q <= '0;
      mreg_q    <= '0;
      cnt_q     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q     <= {{WIDTH{a[WIDTH-1]}}, a};
            mreg_q  <= {b, 1'b0};
            acc_q   <= '0;
            cnt_q   <= '0;
            state_q <= RUN;
          end
        end
        RUN: begin
          acc_q  <= acc_d;
          mreg_q <= mreg_d;
          cnt_q  <= cnt_q + 1'b1;
          if (finish) begin
            product_q <= acc_d;
            state_q   <= DONE;
          end
        end
        DONE: begin
          if (out_ready) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // in_ready is masked by rst so it reads 0 during the reset cycle itself.
  assign in_ready  = (state_q == IDLE) & ~rst;
  assign busy      = (state_q == RUN);
  assign out_valid = (state_q == DONE);
  assign product   = product_q;

endmodule

// File: tb/tb_booth_seq_mult.sv
// Directed-vector bench for booth_seq_mult (WIDTH=16): products, latency, handshake stalls and reset abort.
module tb_booth_seq_mult;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a, b;
  logic        busy;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] product;

  int unsigned total  = 0;
  int unsigned passed = 0;

  booth_seq_mult #(.WIDTH(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .busy(busy), .out_valid(out_valid),
    .out_ready(out_ready), .product(product)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [31:0] p;
    int          lat_skip;
  } vec_t;

  vec_t vecs[13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  function automatic int exp_lat(input int lat_skip);
`ifdef BOOTH_SKIP_EN
    return lat_skip;
`else
    return 8;
`endif
  endfunction

  // One full transaction with out_ready=1: accept, count edges to out_valid, then consume.
  task automatic do_op(input string name, input logic [15:0] va, input logic [15:0] vb,
                       input logic [31:0] ep, input int lat_skip);
    int cyc;
    @(negedge clk);
    check({name, ".in_ready"}, {31'd0, in_ready}, 32'd1);
    a = va; b = vb; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = 16'hDEAD; b = 16'hBEEF;
    cyc = 0;
    while (!out_valid && cyc < 50) begin
      @(posedge clk); #1;
      cyc++;
    end
    check({name, ".latency"}, 32'(cyc), 32'(exp_lat(lat_skip)));
    check({name, ".product"}, product, ep);
    @(posedge clk); #1;
    check({name, ".ready_after"}, {30'd0, in_ready, out_valid}, 32'b10);
  endtask

  initial begin
    int cyc;
    vecs[0]  = '{16'd3,    16'd5,    32'h0000000F, 2};
    vecs[1]  = '{16'hFFF9, 16'd6,    32'hFFFFFFD6, 2};
    vecs[2]  = '{16'h8000, 16'h8000, 32'h40000000, 8};
    vecs[3]  = '{16'h8000, 16'h7FFF, 32'hC0008000, 8};
    vecs[4]  = '{16'd5,    16'd1,    32'h00000005, 1};
    vecs[5]  = '{16'd9,    16'hFFFF, 32'hFFFFFFF7, 1};
    vecs[6]  = '{16'd3,    16'h4000, 32'h0000C000, 8};
    vecs[7]  = '{16'h1234, 16'h0000, 32'h00000000, 1};
    vecs[8]  = '{16'h7FFF, 16'h7FFF, 32'h3FFF0001, 8};
    vecs[9]  = '{16'hFFFF, 16'hFFFF, 32'h00000001, 1};
    vecs[10] = '{16'h0100, 16'hFF00, 32'hFFFF0000, 5};
    vecs[11] = '{16'hFF9C, 16'h0025, 32'hFFFFF18C, 4};
    vecs[12] = '{16'd11,   16'd13,   32'h0000008F, 3};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst.in_ready", {31'd0, in_ready}, 32'd0);
    check("rst.flags", {30'd0, busy, out_valid}, 32'd0);
    check("rst.product", product, 32'd0);
    @(negedge clk); rst = 1'b0;
    #1;
    check("post_rst.in_ready", {31'd0, in_ready}, 32'd1);

    for (int i = 0; i < 12; i++)
      do_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].p, vecs[i].lat_skip);

    // Consumer stall: DONE holds for 5 cycles while a new request is presented and ignored.
    @(negedge clk);
    a = vecs[12].a; b = vecs[12].b; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    cyc = 0;
    while (!out_valid && cyc < 50) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("stall.latency", 32'(cyc), 32'(exp_lat(vecs[12].lat_skip)));
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      a = 16'd1; b = 16'd1; in_valid = 1'b1;
      @(posedge clk); #1;
      check($sformatf("stall%0d.hold", k), {29'd0, out_valid, in_ready, busy}, 32'b100);
      check($sformatf("stall%0d.product", k), product, vecs[12].p);
    end
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("stall.accepted", {29'd0, out_valid, in_ready, busy}, 32'b010);
    check("stall.product_hold", product, vecs[12].p);
    @(posedge clk); #1;
    check("stall.no_capture", {29'd0, out_valid, in_ready, busy}, 32'b010);

    // Reset abort during digit 3 of a run.
    @(negedge clk);
    a = 16'h1234; b = 16'h5678; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("abort.busy", {31'd0, busy}, 32'd1);
    repeat (3) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    check("abort.flags", {29'd0, out_valid, in_ready, busy}, 32'b000);
    check("abort.product", product, 32'd0);
    @(negedge clk); rst = 1'b0;
    #1;
    check("abort.in_ready", {31'd0, in_ready}, 32'd1);
    repeat (10) begin
      @(posedge clk); #1;
      if (out_valid) check("abort.spurious_valid", 32'd1, 32'd0);
    end
    do_op("after_abort", 16'd2, 16'd2, 32'd4, 2);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
